spi_master_arb: RTL
===================

Name: spi_master_arb

Overview:
- Round-robin arbiter and frame sequencer that shares one SPI link among NUM_REQ on-chip requesters.
- Grants one requester at a time, latches its word, and drives cs/mosi for one fixed-length frame.
- Samples miso into a receive word and returns it with a one-cycle done pulse.
- Sits between the requester fabric and the SPI pins; the far end is our 16-bit spi_slave (cs active-high, one bit per clk, LSB first).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, frame width in bits.
- GAP_CYCLES, 2, minimum cs-low cycles between frames (>=1).

Ports:
- clk  in  1  system clock; SPI bit rate = clk.
- rst  in  1  reset, synchronous, active-high.
- req  in  NUM_REQ  per-requester transfer request (level).
- tx_data  in  NUM_REQ*DATA_W  requester i's word in bits [i*DATA_W +: DATA_W].
- grant  out  NUM_REQ  one-hot owner of the current frame.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse, frame complete.
- rx_data  out  DATA_W  word received from miso; valid when done=1, held until next done.
- cs  out  1  SPI chip select, active-high.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.

Behaviour:
- Reset (sync, clk): state=IDLE, grant=0, busy=0, done=0, rx_data=0, cs=0, mosi=0, rr_ptr=0, bit_cnt=0, gap_cnt=0. A reset mid-frame drops cs on that edge. No partial done is emitted.
- States: IDLE, SELECT, SHIFT, DONE, GAP.
- IDLE:
  - If any req bit is set, pick the winner by round robin: the first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - Latch that requester's tx_data into tx_sh and set grant to one-hot.
  - Set cs=1 and go to SELECT.
  - Set rr_ptr=(winner+1) mod NUM_REQ.
  - With no req, stay in IDLE with cs=0.
- SELECT (1 cycle): cs=1, mosi=0, bit_cnt=0, then go to SHIFT. This matches the slave's one-cycle IDLE->transfer latency.
- SHIFT (DATA_W cycles):
  - Each cycle: mosi=tx_sh[bit_cnt], rx_sh[bit_cnt]<=miso, bit_cnt++.
  - After bit DATA_W-1, go to DONE.
- DONE (1 cycle): cs=0, mosi=0, rx_data<=rx_sh, done=1, grant cleared at the end of this cycle. Load gap_cnt=GAP_CYCLES-1, then go to GAP.
- GAP: cs=0. Decrement gap_cnt; at 0 go to IDLE.
- Frame latency, req seen to done: 1+1+DATA_W+1 = 19 cycles at the defaults. Back-to-back frame period: 19+GAP_CYCLES.
- Handshake:
  - A requester holds req and tx_data until the cycle after it sees grant. tx_data is sampled only in IDLE.
  - Deasserting req mid-frame does not abort; the frame completes and done still pulses.
  - A requester keeping req high after done re-competes at the normal round-robin priority.
- Simultaneous requests: strictly round robin. No requester waits more than NUM_REQ-1 frames.
- bit_cnt width: $clog2(DATA_W)+1. No wrap inside SHIFT.
- Outputs cs, mosi, grant, done and busy are registered (no combinational path from req or miso).

Optional Feature:
- Macro: SPI_MSB_FIRST_EN.
- Defined: SHIFT drives mosi=tx_sh[DATA_W-1-bit_cnt] and stores miso into rx_sh[DATA_W-1-bit_cnt]. Bit order is MSB first, for non-legacy peripherals.
- Undefined (default): LSB first as above, compatible with spi_slave.
- Timing and handshake are identical in both builds.

Decomposition:
- Shared package spi_pkg:
  - state encoding constants (IDLE, SELECT, SHIFT, DONE, GAP, 3 bits);
  - the DATA_W default;
  - the GAP_CYCLES default.
- One sub-module, rr_arbiter: combinational round-robin pick. Inputs req and rr_ptr; outputs a one-hot winner and its index. The FSM, shifters and counters stay in spi_master_arb.

Test Plan:
- Single frame: req=4'b0001, tx_data[15:0]=16'hA5C3, miso looped from a spi_slave model with data_in=16'h1234.
  -> grant=0001 one cycle later, cs high for 17 cycles, done 19 cycles after req, rx_data captures the slave's output, and the slave's slave_r reaches 16'hA5C3 before STOP clears it.
- Contention: req=4'b1111 held, each requester's tx_data distinct.
  -> grant order 0001, 0010, 0100, 1000, 0001, with frames spaced 19+2=21 cycles.
- Fairness with rr_ptr=2: req=4'b0011 -> grant=0001 first, then 0010, never starving either.
- Reset mid-frame: assert rst at bit 7 of SHIFT.
  -> next edge cs=0, grant=0, busy=0, no done. A new req after reset starts a clean frame with rr_ptr=0.
- req dropped during SHIFT -> the frame still completes, done pulses once, and no new grant is issued to that requester.
- With SPI_MSB_FIRST_EN defined, tx_data=16'h8001 -> mosi sequence 1,0,…,0,1 driven MSB first; miso stream 16'hF00F is reconstructed exactly in rx_data.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master arbiter: FSM state encoding and
// default frame geometry.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        SHIFT  = 3'd2,
        DONE   = 3'd3,
        GAP    = 3'd4
    } state_t;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_GAP_CYCLES = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               valid
);

    int j;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        j          = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(rr_ptr) + i) % NUM_REQ;
            if (!valid && req[IDX_W'(j)]) begin
                valid              = 1'b1;
                winner[IDX_W'(j)]  = 1'b1;
                winner_idx         = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/spi_master_arb.sv
// Round-robin SPI frame sequencer sharing one cs/mosi/miso link among NUM_REQ
// requesters. Define SPI_MSB_FIRST_EN for MSB-first bit order (default LSB first).
module spi_master_arb
    import spi_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] tx_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_W-1:0]         rx_data,
    output logic                      cs,
    output logic                      mosi,
    input  logic                      miso
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BIT_W = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

    state_t               state, state_nxt;
    logic [DATA_W-1:0]    tx_sh, rx_sh, rx_sh_nxt, sel_word;
    logic [CNT_W-1:0]     bit_cnt;
    logic [GAP_W-1:0]     gap_cnt;
    logic [IDX_W-1:0]     rr_ptr, arb_idx;
    logic [NUM_REQ-1:0]   arb_winner, grant_nxt;
    logic                 arb_valid;
    logic [BIT_W-1:0]     next_pos;
    logic                 cs_nxt, mosi_nxt, done_nxt, busy_nxt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req),
        .rr_ptr     (rr_ptr),
        .winner     (arb_winner),
        .winner_idx (arb_idx),
        .valid      (arb_valid)
    );

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) sel_word = tx_data[i*DATA_W +: DATA_W];
        end
    end

    function automatic logic [BIT_W-1:0] bit_pos(input logic [BIT_W-1:0] k);
`ifdef SPI_MSB_FIRST_EN
        return BIT_W'(DATA_W - 1) - k;
`else
        return k;
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_valid) state_nxt = SELECT;
            SELECT:  state_nxt = SHIFT;
            SHIFT:   if (bit_cnt == CNT_W'(DATA_W - 1)) state_nxt = DONE;
            DONE:    state_nxt = GAP;
            GAP:     if (gap_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so every pin comes straight off a flop.
    always_comb begin
        next_pos  = (state == SHIFT) ? bit_cnt[BIT_W-1:0] + 1'b1 : '0;
        cs_nxt    = (state_nxt == SELECT) || (state_nxt == SHIFT);
        mosi_nxt  = (state_nxt == SHIFT) ? tx_sh[bit_pos(next_pos)] : 1'b0;
        done_nxt  = (state_nxt == DONE);
        busy_nxt  = (state_nxt != IDLE);
        grant_nxt = grant;
        if (state == IDLE)      grant_nxt = arb_valid ? arb_winner : '0;
        else if (state == DONE) grant_nxt = '0;
        rx_sh_nxt = rx_sh;
        if (state == SHIFT) rx_sh_nxt[bit_pos(bit_cnt[BIT_W-1:0])] = miso;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cs      <= 1'b0;
            mosi    <= 1'b0;
            rx_data <= '0;
            rx_sh   <= '0;
            tx_sh   <= '0;
            rr_ptr  <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            grant   <= grant_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            cs      <= cs_nxt;
            mosi    <= mosi_nxt;
            rx_sh   <= rx_sh_nxt;
            bit_cnt <= (state == SHIFT) ? bit_cnt + 1'b1 : '0;
            if (state == IDLE && arb_valid) begin
                tx_sh  <= sel_word;
                rr_ptr <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            end
            // The final miso bit is folded in directly so rx_data is valid alongside done.
            if (state_nxt == DONE) rx_data <= rx_sh_nxt;
            if (state == DONE)
                gap_cnt <= GAP_W'(GAP_CYCLES - 1);
            else if (state == GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - 1'b1;
        end
    end

endmodule
